// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial add/subtract unit:
// FSM state encoding and the legal-parameter check.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic bit legal_params(int w, int d);
      return (d > 0) && (w >= d) && ((w % d) == 0);
   endfunction

endpackage

// File: rtl/ripple_slice.sv
// DIGIT-bit ripple-carry slice built from chained full adders.
// c_msb is the carry into the top bit, used for signed overflow.
module ripple_slice #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   always_comb begin
      c[0] = ci;
      sum  = '0;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co    = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract, DIGIT bits per clock,
// with start/done handshake and signed-overflow flag.
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (!legal_params(WIDTH, DIGIT)) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
   end

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    cnt;
   logic             carry;

   logic [DIGIT-1:0] sum;
   logic             co;
   logic             c_msb;

   ripple_slice #(.DIGIT(DIGIT)) u_slice (
      .x     (a_q[DIGIT-1:0]),
      .y     (b_q[DIGIT-1:0]),
      .ci    (carry),
      .sum   (sum),
      .co    (co),
      .c_msb (c_msb)
   );

   // Operands shift right so the slice always sees the low digit.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         s        <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
         ready    <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : c_in;
                  cnt   <= '0;
                  ready <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               s[int'(cnt)*DIGIT +: DIGIT] <= sum;
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               carry <= co;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(N-1)) begin
                  c_out    <= co;
                  overflow <= c_msb ^ co;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
